// File: rtl/bus_control_sequencer.sv
// Microcode sequencer for the 8-bit CPU. A step counter walks fetch (T0-T1)
// and opcode-dependent execute steps (T2-T4). Every bus strobe is a
// combinational decode of the registered step, the opcode nibble and the
// latched ALU flags, so target registers sample the strobes on the next edge.
module bus_control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEP_WIDTH   = 3
) (
    input  logic                    i_CLOCK,
    input  logic                    i_CLEAR,
    input  logic [OPCODE_WIDTH-1:0] i_OPCODE,
    input  logic                    i_FLAG_CARRY,
    input  logic                    i_FLAG_ZERO,
    output logic                    o_PC_WRITE_BUS,
    output logic                    o_PC_READ_BUS,
    output logic                    o_PC_INCREMENT,
    output logic                    o_MAR_READ_BUS,
    output logic                    o_RAM_WRITE_BUS,
    output logic                    o_RAM_READ_BUS,
    output logic                    o_IR_READ_BUS,
    output logic                    o_IR_WRITE_BUS,
    output logic                    o_A_READ_BUS,
    output logic                    o_A_WRITE_BUS,
    output logic                    o_B_READ_BUS,
    output logic                    o_ALU_WRITE_BUS,
    output logic                    o_ALU_SUBTRACT,
    output logic                    o_FLAGS_LOAD,
    output logic                    o_OUT_READ_BUS,
    output logic [STEP_WIDTH-1:0]   o_TSTATE,
    output logic                    o_INSTR_DONE,
    output logic                    o_HALTED
);

    // Step numbers
    localparam logic [STEP_WIDTH-1:0] T0 = STEP_WIDTH'(0);
    localparam logic [STEP_WIDTH-1:0] T1 = STEP_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] T2 = STEP_WIDTH'(2);
    localparam logic [STEP_WIDTH-1:0] T3 = STEP_WIDTH'(3);
    localparam logic [STEP_WIDTH-1:0] T4 = STEP_WIDTH'(4);

    // Opcode map; anything not listed executes as NOP
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

    // One control word per cycle; exactly the strobes the datapath sees
    typedef struct packed {
        logic pc_write_bus;
        logic pc_read_bus;
        logic pc_increment;
        logic mar_read_bus;
        logic ram_write_bus;
        logic ram_read_bus;
        logic ir_read_bus;
        logic ir_write_bus;
        logic a_read_bus;
        logic a_write_bus;
        logic b_read_bus;
        logic alu_write_bus;
        logic alu_subtract;
        logic flags_load;
        logic out_read_bus;
    } ctrl_t;

    ctrl_t                 ctrl;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic                  halted_q, halted_d;
    logic                  last_step;

    // State register: clear wins over everything, including a halted core
    always_ff @(posedge i_CLOCK) begin
        if (i_CLEAR) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Microcode decode: strobes for the current step plus next step/halt state
    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        step_d    = step_q + STEP_WIDTH'(1);
        halted_d  = halted_q;

        if (i_CLEAR) begin
            // Outputs held quiet; the register block handles the reset itself
            step_d = T0;
        end else if (halted_q) begin
            step_d = step_q;
        end else begin
            case (step_q)
                T0: begin
                    ctrl.pc_write_bus = 1'b1;
                    ctrl.mar_read_bus = 1'b1;
                end
                T1: begin
                    ctrl.ram_write_bus = 1'b1;
                    ctrl.ir_read_bus   = 1'b1;
                    ctrl.pc_increment  = 1'b1;
                    case (i_OPCODE)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
                        OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: ;
                        default: last_step = 1'b1;   // NOP and undefined
                    endcase
                end
                T2: begin
                    case (i_OPCODE)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl.ir_write_bus = 1'b1;
                            ctrl.mar_read_bus = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl.ir_write_bus = 1'b1;
                            ctrl.a_read_bus   = 1'b1;
                            last_step         = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl.ir_write_bus = 1'b1;
                            ctrl.pc_read_bus  = 1'b1;
                            last_step         = 1'b1;
                        end
                        OP_JC: begin
                            ctrl.ir_write_bus = i_FLAG_CARRY;
                            ctrl.pc_read_bus  = i_FLAG_CARRY;
                            last_step         = 1'b1;
                        end
                        OP_JZ: begin
                            ctrl.ir_write_bus = i_FLAG_ZERO;
                            ctrl.pc_read_bus  = i_FLAG_ZERO;
                            last_step         = 1'b1;
                        end
                        OP_OUT: begin
                            ctrl.a_write_bus  = 1'b1;
                            ctrl.out_read_bus = 1'b1;
                            last_step         = 1'b1;
                        end
                        OP_HLT: begin
                            // Park on T2; not a completion, so no done pulse
                            step_d   = step_q;
                            halted_d = 1'b1;
                        end
                        default: last_step = 1'b1;
                    endcase
                end
                T3: begin
                    case (i_OPCODE)
                        OP_LDA: begin
                            ctrl.ram_write_bus = 1'b1;
                            ctrl.a_read_bus    = 1'b1;
                            last_step          = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.ram_write_bus = 1'b1;
                            ctrl.b_read_bus    = 1'b1;
                        end
                        OP_STA: begin
                            ctrl.a_write_bus  = 1'b1;
                            ctrl.ram_read_bus = 1'b1;
                            last_step         = 1'b1;
                        end
                        // Opcode changed under us: finish quietly
                        default: last_step = 1'b1;
                    endcase
                end
                T4: begin
                    if (i_OPCODE == OP_ADD || i_OPCODE == OP_SUB) begin
                        ctrl.alu_write_bus = 1'b1;
                        ctrl.a_read_bus    = 1'b1;
                        ctrl.flags_load    = 1'b1;
                        ctrl.alu_subtract  = (i_OPCODE == OP_SUB);
                    end
                    last_step = 1'b1;
                end
                default: begin
                    // Illegal step value: no strobes, back to fetch
                    step_d = T0;
                end
            endcase
            if (last_step) step_d = T0;
        end
    end

    assign o_PC_WRITE_BUS  = ctrl.pc_write_bus;
    assign o_PC_READ_BUS   = ctrl.pc_read_bus;
    assign o_PC_INCREMENT  = ctrl.pc_increment;
    assign o_MAR_READ_BUS  = ctrl.mar_read_bus;
    assign o_RAM_WRITE_BUS = ctrl.ram_write_bus;
    assign o_RAM_READ_BUS  = ctrl.ram_read_bus;
    assign o_IR_READ_BUS   = ctrl.ir_read_bus;
    assign o_IR_WRITE_BUS  = ctrl.ir_write_bus;
    assign o_A_READ_BUS    = ctrl.a_read_bus;
    assign o_A_WRITE_BUS   = ctrl.a_write_bus;
    assign o_B_READ_BUS    = ctrl.b_read_bus;
    assign o_ALU_WRITE_BUS = ctrl.alu_write_bus;
    assign o_ALU_SUBTRACT  = ctrl.alu_subtract;
    assign o_FLAGS_LOAD    = ctrl.flags_load;
    assign o_OUT_READ_BUS  = ctrl.out_read_bus;
    assign o_TSTATE        = i_CLEAR ? T0 : step_q;
    assign o_INSTR_DONE    = last_step;
    assign o_HALTED        = halted_q;

endmodule
